// File: rtl/nibbler_bridge_pkg.sv
// Shared types and bit positions for the NIBBLER host bridge.
// Status and control indices match the CPU-visible IN_2 / OUT_2 layouts.
package nibbler_bridge_pkg;

  typedef logic [3:0] nibble_t;

  localparam int unsigned NIBBLE_W = 4;

  // IN_2 status bit positions
  localparam int unsigned ST_RX_NONEMPTY = 0;
  localparam int unsigned ST_TX_FULL     = 1;
  localparam int unsigned ST_TX_EMPTY    = 2;
  localparam int unsigned ST_TX_OVF      = 3;

  // OUT_2 control bit positions
  localparam int unsigned CT_TX_TOG  = 0;
  localparam int unsigned CT_RX_TOG  = 1;
  localparam int unsigned CT_OVF_CLR = 3;

  // Packs the four status flags into the IN_2 nibble.
  function automatic nibble_t pack_status(input logic rx_nonempty,
                                          input logic tx_full,
                                          input logic tx_empty,
                                          input logic tx_ovf);
    nibble_t st;
    st                 = '0;
    st[ST_RX_NONEMPTY] = rx_nonempty;
    st[ST_TX_FULL]     = tx_full;
    st[ST_TX_EMPTY]    = tx_empty;
    st[ST_TX_OVF]      = tx_ovf;
    return st;
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Circular nibble FIFO with wrap-around pointers and an occupancy count.
// Push while full is accepted only when a pop lands in the same cycle.
module nibble_fifo
  import nibbler_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  nibble_t din,
  output nibble_t dout,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  nibble_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok_c;
  logic            pop_ok_c;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Pop is qualified first so a full FIFO can still take a same-cycle push.
  always_comb begin
    pop_ok_c  = pop && !empty;
    push_ok_c = push && (!full || pop_ok_c);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/nibbler_host_bridge.sv
// Bridges NIBBLER's OUT_0/OUT_2/IN_0/IN_2 port pins to a host valid/ready stream.
// OUT_2 bit toggles stand in for the CPU's missing write/read strobes.
module nibbler_host_bridge
  import nibbler_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  nibble_t cpu_out0,
  input  nibble_t cpu_out2,
  output nibble_t cpu_in0,
  output nibble_t cpu_in2,
  output nibble_t tx_data,
  output logic    tx_valid,
  input  logic    tx_ready,
  input  nibble_t rx_data,
  input  logic    rx_valid,
  output logic    rx_ready
);

  logic    tx_tog_q, tx_tog_d;
  logic    rx_tog_q, rx_tog_d;
  logic    tx_ovf_q, tx_ovf_d;

  logic    tx_evt_c;
  logic    rx_evt_c;
  logic    tx_pop_c;
  logic    tx_drop_c;
  logic    rx_push_c;
  logic    tx_full_c, tx_empty_c;
  logic    rx_full_c, rx_empty_c;
  nibble_t tx_head_c, rx_head_c;
  logic    unused_ctl_c;

  assign unused_ctl_c = cpu_out2[2];

  // Toggle detection, host handshakes and the overflow decision.
  always_comb begin
    tx_tog_d  = cpu_out2[CT_TX_TOG];
    rx_tog_d  = cpu_out2[CT_RX_TOG];
    tx_evt_c  = cpu_out2[CT_TX_TOG] != tx_tog_q;
    rx_evt_c  = cpu_out2[CT_RX_TOG] != rx_tog_q;
    tx_pop_c  = !tx_empty_c && tx_ready;
    rx_push_c = rx_valid && !rx_full_c;
    tx_drop_c = tx_evt_c && tx_full_c && !tx_pop_c;
    tx_ovf_d  = tx_ovf_q;
    if (tx_drop_c) begin
      tx_ovf_d = 1'b1;
    end else if (cpu_out2[CT_OVF_CLR]) begin
      tx_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_tog_q <= 1'b0;
      rx_tog_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      tx_tog_q <= tx_tog_d;
      rx_tog_q <= rx_tog_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

  nibble_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_evt_c),
    .pop   (tx_pop_c),
    .din   (cpu_out0),
    .dout  (tx_head_c),
    .full  (tx_full_c),
    .empty (tx_empty_c)
  );

  nibble_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push_c),
    .pop   (rx_evt_c),
    .din   (rx_data),
    .dout  (rx_head_c),
    .full  (rx_full_c),
    .empty (rx_empty_c)
  );

  // All outputs decode registered FIFO/flag state only.
  assign tx_data  = tx_head_c;
  assign tx_valid = !tx_empty_c;
  assign rx_ready = !rx_full_c;
  assign cpu_in0  = rx_head_c;
  assign cpu_in2  = pack_status(!rx_empty_c, tx_full_c, tx_empty_c, tx_ovf_q);

endmodule

// File: tb/tb_nibbler_host_bridge.sv
// Self-checking bench for nibbler_host_bridge: directed scenarios plus random
// traffic compared against a queue-based model of the bridge behaviour.
module tb_nibbler_host_bridge;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] cpu_out0;
  logic [3:0] cpu_out2;
  logic [3:0] cpu_in0;
  logic [3:0] cpu_in2;
  logic [3:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_tx[$];
  logic [3:0] m_rx[$];
  logic       m_ovf;
  logic       m_prev_tx;
  logic       m_prev_rx;

  nibbler_host_bridge #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .cpu_out0 (cpu_out0),
    .cpu_out2 (cpu_out2),
    .cpu_in0  (cpu_in0),
    .cpu_in2  (cpu_in2),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_tx.delete();
    m_rx.delete();
    m_ovf     = 1'b0;
    m_prev_tx = 1'b0;
    m_prev_rx = 1'b0;
  endtask

  // One clock edge of bridge behaviour, from the inputs currently applied.
  task automatic model_step();
    int tsz, rsz;
    bit tx_evt, rx_evt, tx_pop, rx_push, rx_pop, drop;
    tsz     = m_tx.size();
    rsz     = m_rx.size();
    tx_evt  = (cpu_out2[0] != m_prev_tx);
    rx_evt  = (cpu_out2[1] != m_prev_rx);
    tx_pop  = (tsz > 0) && tx_ready;
    rx_push = rx_valid && (rsz < DEPTH);
    rx_pop  = rx_evt && (rsz > 0);
    drop    = 1'b0;
    if (tx_pop) void'(m_tx.pop_front());
    if (tx_evt) begin
      if (tsz < DEPTH || tx_pop) m_tx.push_back(cpu_out0);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (cpu_out2[3]) m_ovf = 1'b0;
    if (rx_pop) void'(m_rx.pop_front());
    if (rx_push) m_rx.push_back(rx_data);
    m_prev_tx = cpu_out2[0];
    m_prev_rx = cpu_out2[1];
  endtask

  function automatic logic [13:0] exp_vec();
    logic [3:0] in0, in2, td;
    in0 = (m_rx.size() > 0) ? m_rx[0] : 4'h0;
    td  = (m_tx.size() > 0) ? m_tx[0] : 4'h0;
    in2 = {m_ovf, m_tx.size() == 0, m_tx.size() == DEPTH, m_rx.size() > 0};
    return {in0, in2, td, m_tx.size() > 0, m_rx.size() < DEPTH};
  endfunction

  function automatic logic [13:0] obs_vec();
    return {cpu_in0, cpu_in2, tx_data, tx_valid, rx_ready};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tog_tx(input logic [3:0] d);
    cpu_out0    = d;
    cpu_out2[0] = ~cpu_out2[0];
    tick();
  endtask

  task automatic tog_rx();
    cpu_out2[1] = ~cpu_out2[1];
    tick();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    cpu_out0 = '0;
    cpu_out2 = '0;
    tx_ready = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== {4'h0, 4'b0100, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", obs_vec(), {4'h0, 4'b0100, 4'h0, 1'b0, 1'b1});
    end
    #3 rst_n = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_tx_basic();
    tx_ready = 1'b1;
    tog_tx(4'hA);
    checks++;
    if ({tx_valid, tx_data, cpu_in2[2]} !== {1'b1, 4'hA, 1'b0}) begin
      errors++;
      $display("FAIL tx_basic_head got v=%b d=%h e=%b exp v=1 d=a e=0", tx_valid, tx_data, cpu_in2[2]);
    end
    tick();
    checks++;
    if ({tx_valid, cpu_in2[2]} !== 2'b01 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL tx_basic_pop got v=%b e=%b exp v=0 e=1", tx_valid, cpu_in2[2]);
    end
  endtask

  task automatic test_tx_overflow();
    tx_ready = 1'b0;
    for (int k = 1; k <= 4; k++) tog_tx(4'(k));
    checks++;
    if (cpu_in2[1] !== 1'b1 || cpu_in2[3] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full got in2=%b exp full=1 ovf=0", cpu_in2);
    end
    tog_tx(4'h5);
    checks++;
    if (cpu_in2[3] !== 1'b1 || cpu_in2[1] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got in2=%b exp full=1 ovf=1", cpu_in2);
    end
    tx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 4'(k)) begin
        errors++;
        $display("FAIL ovf_drain_%0d got v=%b d=%h exp v=1 d=%h", k, tx_valid, tx_data, 4'(k));
      end
      tick();
    end
    checks++;
    if (tx_valid !== 1'b0 || cpu_in2[3] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got v=%b in2=%b exp v=0 ovf=1", tx_valid, cpu_in2);
    end
    cpu_out2[3] = 1'b1;
    tick();
    cpu_out2[3] = 1'b0;
    checks++;
    if (cpu_in2[3] !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL ovf_clear got in2=%b exp ovf=0", cpu_in2);
    end
  endtask

  task automatic test_full_push_pop();
    logic [3:0] exp_order [4];
    exp_order[0] = 4'h2; exp_order[1] = 4'h3; exp_order[2] = 4'h4; exp_order[3] = 4'h6;
    tx_ready = 1'b0;
    for (int k = 1; k <= 4; k++) tog_tx(4'(k));
    tx_ready = 1'b1;
    tog_tx(4'h6);
    checks++;
    if (cpu_in2[1] !== 1'b1 || cpu_in2[3] !== 1'b0 || tx_data !== 4'h2) begin
      errors++;
      $display("FAIL full_pushpop got in2=%b d=%h exp full=1 ovf=0 d=2", cpu_in2, tx_data);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_order[k]) begin
        errors++;
        $display("FAIL full_pushpop_order_%0d got %h exp %h", k, tx_data, exp_order[k]);
      end
      tick();
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_basic();
    rx_valid = 1'b1;
    rx_data  = 4'h7;
    tick();
    rx_data  = 4'h9;
    tick();
    rx_valid = 1'b0;
    checks++;
    if (cpu_in0 !== 4'h7 || cpu_in2[0] !== 1'b1) begin
      errors++;
      $display("FAIL rx_first got in0=%h ne=%b exp in0=7 ne=1", cpu_in0, cpu_in2[0]);
    end
    tog_rx();
    checks++;
    if (cpu_in0 !== 4'h9 || cpu_in2[0] !== 1'b1) begin
      errors++;
      $display("FAIL rx_second got in0=%h ne=%b exp in0=9 ne=1", cpu_in0, cpu_in2[0]);
    end
    tog_rx();
    checks++;
    if (cpu_in0 !== 4'h0 || cpu_in2[0] !== 1'b0) begin
      errors++;
      $display("FAIL rx_empty got in0=%h ne=%b exp in0=0 ne=0", cpu_in0, cpu_in2[0]);
    end
    tog_rx();
    checks++;
    if (cpu_in0 !== 4'h0 || cpu_in2[0] !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL rx_pop_empty got in0=%h ne=%b exp in0=0 ne=0", cpu_in0, cpu_in2[0]);
    end
  endtask

  task automatic test_rx_backpressure();
    int accepted = 0;
    int guard    = 0;
    rx_valid = 1'b1;
    rx_data  = 4'h1;
    while (accepted < 4 && guard < 20) begin
      if (m_rx.size() < DEPTH) begin
        tick();
        accepted++;
        rx_data = 4'(accepted + 1);
      end else tick();
      guard++;
    end
    checks++;
    if (rx_ready !== 1'b0 || accepted != 4) begin
      errors++;
      $display("FAIL rx_bp_full got rdy=%b acc=%0d exp rdy=0 acc=4", rx_ready, accepted);
    end
    tick();
    tick();
    checks++;
    if (rx_ready !== 1'b0 || cpu_in0 !== 4'h1) begin
      errors++;
      $display("FAIL rx_bp_hold got rdy=%b in0=%h exp rdy=0 in0=1", rx_ready, cpu_in0);
    end
    tog_rx();
    checks++;
    if (rx_ready !== 1'b1 || cpu_in0 !== 4'h2) begin
      errors++;
      $display("FAIL rx_bp_pop got rdy=%b in0=%h exp rdy=1 in0=2", rx_ready, cpu_in0);
    end
    tick();
    rx_valid = 1'b0;
    checks++;
    if (rx_ready !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL rx_bp_accept5 got %h exp %h", obs_vec(), exp_vec());
    end
    for (int k = 2; k <= 5; k++) begin
      checks++;
      if (cpu_in0 !== 4'(k)) begin
        errors++;
        $display("FAIL rx_bp_order_%0d got %h exp %h", k, cpu_in0, 4'(k));
      end
      tog_rx();
    end
  endtask

  task automatic test_reset_mid_traffic();
    tx_ready = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 4'hC;
    for (int k = 0; k < 3; k++) tog_tx(4'(k + 8));
    checks++;
    if (tx_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL mid_reset_pre got %h exp %h", obs_vec(), exp_vec());
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || cpu_in2 !== 4'b0100 || rx_ready !== 1'b1 || cpu_in0 !== 4'h0 || tx_data !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset_async got v=%b in2=%b rdy=%b in0=%h d=%h exp v=0 in2=0100 rdy=1 in0=0 d=0",
               tx_valid, cpu_in2, rx_ready, cpu_in0, tx_data);
    end
    cpu_out2 = '0;
    rx_valid = 1'b0;
    model_clear();
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL mid_reset_after got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 2) == 0) cpu_out2[0] = ~cpu_out2[0];
      if ($urandom_range(0, 2) == 0) cpu_out2[1] = ~cpu_out2[1];
      cpu_out2[2] = 1'($urandom);
      cpu_out2[3] = ($urandom_range(0, 15) == 0);
      cpu_out0    = 4'($urandom);
      tx_ready    = ($urandom_range(0, 3) != 0) ? (c % 400 > 150) : 1'b0;
      rx_valid    = 1'($urandom);
      rx_data     = 4'($urandom);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_c%0d got %h exp %h", c, obs_vec(), exp_vec());
      end
    end
    cpu_out2[3] = 1'b0;
    tx_ready    = 1'b0;
    rx_valid    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_full_push_pop();
    test_rx_basic();
    test_rx_backpressure();
    test_reset_mid_traffic();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
